// File: rtl/call_stack_if.sv
// Call/return request bus and stack status for the hardware call stack.
// Latency: none, this is wiring only; the registered timing lives in call_stack.
// Backpressure: none; a refused request is reported through the sticky overflow/underflow flags.
interface call_stack_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              call;
   logic              ret;
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] target;
   logic              clr_err;
   logic [DATA_W-1:0] pc_next;
   logic              pc_load;
   logic [DATA_W-1:0] top;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              overflow;
   logic              underflow;

   // Requester side: issues call/ret and consumes the jump address.
   modport master (
      output call, ret, pc, target, clr_err,
      input  pc_next, pc_load, top, count, full, empty, overflow, underflow
   );

   // Stack side.
   modport slave (
      input  call, ret, pc, target, clr_err,
      output pc_next, pc_load, top, count, full, empty, overflow, underflow
   );
endinterface

// File: rtl/call_stack.sv
// Hardware return-address stack: a call pushes pc+INSTR_LEN and jumps to target, a ret pops and jumps back.
// Latency: one clock from a sampled request to the pc_load strobe; top/full/empty are combinational.
// Backpressure: none; a call while full or a ret while empty is dropped and raises a sticky error flag.
module call_stack #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int INSTR_LEN = 4
) (
   input logic         clk,
   input logic         rst,
   call_stack_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [DATA_W-1:0] stack_q [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] pc_next_q, pc_next_d;
   logic              pc_load_q, pc_load_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              full_w, empty_w;
   logic              push_w, pop_w;
   logic              ovf_set_w, unf_set_w;
   logic [IDX_W-1:0]  wr_idx_w, top_idx_w;
   logic [DATA_W-1:0] top_w, ret_addr_w;

   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);

   // Call has priority; a ret that coincides with a call is silently dropped.
   assign push_w    = bus.call & ~full_w;
   assign pop_w     = ~bus.call & bus.ret & ~empty_w;
   assign ovf_set_w = bus.call & full_w;
   assign unf_set_w = ~bus.call & bus.ret & empty_w;

   assign wr_idx_w   = IDX_W'(count_q);
   assign top_idx_w  = IDX_W'(count_q - ONE_C);
   // Stale entries above count are never selected; an empty stack reads as zero.
   assign top_w      = empty_w ? '0 : stack_q[top_idx_w];
   // Return address wraps modulo 2^DATA_W.
   assign ret_addr_w = DATA_W'(bus.pc + DATA_W'(INSTR_LEN));

   // Next-state: count, jump address/strobe and sticky flags (a new error beats clr_err).
   always_comb begin
      count_d   = count_q;
      pc_next_d = pc_next_q;
      pc_load_d = 1'b0;
      if (push_w) begin
         count_d   = count_q + ONE_C;
         pc_next_d = bus.target;
         pc_load_d = 1'b1;
      end else if (pop_w) begin
         count_d   = count_q - ONE_C;
         pc_next_d = top_w;
         pc_load_d = 1'b1;
      end
      ovf_d = (ovf_q & ~bus.clr_err) | ovf_set_w;
      unf_d = (unf_q & ~bus.clr_err) | unf_set_w;
   end

   // Control state; reset also kills an in-flight pc_load strobe immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         pc_next_q <= '0;
         pc_load_q <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         pc_next_q <= pc_next_d;
         pc_load_q <= pc_load_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   // Entry storage; not reset because count alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push_w && !rst) begin
         stack_q[wr_idx_w] <= ret_addr_w;
      end
   end

   assign bus.pc_next   = pc_next_q;
   assign bus.pc_load   = pc_load_q;
   assign bus.top       = top_w;
   assign bus.count     = count_q;
   assign bus.full      = full_w;
   assign bus.empty     = empty_w;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
endmodule
